// File: rtl/instruction_cache_if.sv
// Instruction cache bus bundle.
// Groups the instruction-unit fetch handshake and the memory-controller fill
// channel into one interface.
//   addrValid/addrIn                     : fetch request (instruction unit -> cache)
//   instrOutValid/instrOut/instrAddrOut  : fetch response (cache -> instruction unit)
//   memRequest/memAddr                   : line fill request (cache -> memory controller)
//   memDataValid/memData                 : fill beats (memory controller -> cache)
// Modports: slave = the cache, master = the environment driving it.
interface instruction_cache_if;
  logic        addrValid;
  logic [31:0] addrIn;
  logic        instrOutValid;
  logic [31:0] instrOut;
  logic [31:0] instrAddrOut;
  logic        memRequest;
  logic [31:0] memAddr;
  logic        memDataValid;
  logic [31:0] memData;

  modport slave (
    input  addrValid, addrIn, memDataValid, memData,
    output instrOutValid, instrOut, instrAddrOut, memRequest, memAddr
  );

  modport master (
    output addrValid, addrIn, memDataValid, memData,
    input  instrOutValid, instrOut, instrAddrOut, memRequest, memAddr
  );
endinterface

// File: rtl/instruction_cache.sv
// Direct-mapped, read-only instruction cache.
// A hit returns the instruction one cycle after the request; a miss fetches
// the whole 4-word line from memory (beats in offset order), installs it and
// then re-looks-up the current address on the following idle cycle.
// Ports:
//   clockIn  : system clock, rising edge
//   resetIn  : asynchronous active-low reset
//   bus      : instruction_cache_if.slave (fetch request/response + fill channel)
//
// state | meaning
// IDLE  | look up addrIn each cycle; hit -> respond, miss -> start fill
// FILL  | collect 4 beats from memory, install line on the last one
module instruction_cache #(
  parameter int INDEX_BITS = 4,
  parameter int LINE_WORDS = 4
) (
  input  logic                clockIn,
  input  logic                resetIn,
  instruction_cache_if.slave  bus
);

  localparam int LINES    = 1 << INDEX_BITS;
  localparam int TAG_BITS = 32 - INDEX_BITS - 4;

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] FILL = 1'b1;

  logic [0:0]          state;
  logic [1:0]          beatCount;
  logic [27:0]         missLine;
  logic [LINES-1:0]    lineValid;
  logic [TAG_BITS-1:0] tagMem  [LINES];
  logic [31:0]         dataMem [LINES][LINE_WORDS];
  logic [31:0]         fillBuf [LINE_WORDS];

  logic                outValid;
  logic [31:0]         outInstr;
  logic [31:0]         outAddr;
  logic                memReq;

  logic [TAG_BITS-1:0]   reqTag;
  logic [INDEX_BITS-1:0] reqIndex;
  logic [1:0]            reqWord;
  logic [TAG_BITS-1:0]   fillTag;
  logic [INDEX_BITS-1:0] fillIndex;
  logic                  hit;
  logic                  beatIn;

  assign reqTag    = bus.addrIn[31:INDEX_BITS+4];
  assign reqIndex  = bus.addrIn[INDEX_BITS+3:4];
  assign reqWord   = bus.addrIn[3:2];
  // missLine holds addr[31:4], so the tag/index of the line being filled
  // sit four bits lower inside it.
  assign fillTag   = missLine[27:INDEX_BITS];
  assign fillIndex = missLine[INDEX_BITS-1:0];
  assign hit       = lineValid[reqIndex] && (tagMem[reqIndex] == reqTag);
  assign beatIn    = (state == FILL) && bus.memDataValid;

  assign bus.instrOutValid = outValid;
  assign bus.instrOut      = outInstr;
  assign bus.instrAddrOut  = outAddr;
  assign bus.memRequest    = memReq;
  assign bus.memAddr       = {missLine, 4'b0000};

  always_ff @(posedge clockIn or negedge resetIn) begin
    if (!resetIn) begin
      state     <= IDLE;
      beatCount <= 2'd0;
      missLine  <= '0;
      lineValid <= '0;
      outValid  <= 1'b0;
      outInstr  <= '0;
      outAddr   <= '0;
      memReq    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.addrValid) begin
            if (hit) begin
              outValid <= 1'b1;
              outInstr <= dataMem[reqIndex][reqWord];
              outAddr  <= bus.addrIn;
            end else begin
              outValid  <= 1'b0;
              memReq    <= 1'b1;
              missLine  <= bus.addrIn[31:4];
              beatCount <= 2'd0;
              state     <= FILL;
            end
          end else begin
            outValid <= 1'b0;
          end
        end
        FILL: begin
          outValid <= 1'b0;
          if (bus.memDataValid) begin
            // 2-bit counter wraps back to 0 on the same edge the line lands.
            beatCount <= beatCount + 2'd1;
            if (beatCount == 2'd3) begin
              lineValid[fillIndex] <= 1'b1;
              memReq               <= 1'b0;
              state                <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Line storage carries no reset: the valid bits alone decide whether a
  // line may be used, and an aborted fill never reaches the install edge.
  always_ff @(posedge clockIn) begin
    if (beatIn) begin
      fillBuf[beatCount] <= bus.memData;
      if (beatCount == 2'd3) begin
        for (int w = 0; w < LINE_WORDS - 1; w++) begin
          dataMem[fillIndex][w] <= fillBuf[w];
        end
        dataMem[fillIndex][LINE_WORDS-1] <= bus.memData;
        tagMem[fillIndex]                <= fillTag;
      end
    end
  end

endmodule

// File: tb/tb_instruction_cache.sv
`timescale 1ns/1ps
module tb_instruction_cache;

  logic clockIn = 1'b0;
  logic resetIn;
  logic checking = 1'b0;

  instruction_cache_if bus();

  instruction_cache #(.INDEX_BITS(4), .LINE_WORDS(4)) dut (
    .clockIn(clockIn),
    .resetIn(resetIn),
    .bus(bus)
  );

  always #5 clockIn = ~clockIn;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%08h want=%08h at %0t", name, got, exp, $time);
    end
  endtask

  // Memory image served by the bench during fills.
  function automatic logic [31:0] memWord(input logic [31:0] a);
    case (a)
      32'h0: return 32'h00000013;
      32'h4: return 32'h00100093;
      32'h8: return 32'h00200113;
      32'hC: return 32'h00300193;
      default: return 32'hC0DE0000 ^ a;
    endcase
  endfunction

  // Model: each of the 16 sets remembers which line base address it holds
  // (-1 = empty) and its four words; a pending fill is a base address plus
  // a list of words received so far.
  longint      lineBase  [16];
  logic [31:0] lineWords [16][4];
  bit          filling;
  int          beats;
  logic [31:0] fillBase;
  logic [31:0] fillWords [4];
  logic        expValid;
  logic [31:0] expInstr;
  logic [31:0] expAddr;
  logic        expReq;
  logic [31:0] expMemAddr;
  int          mSet;

  function void modelReset();
    for (int i = 0; i < 16; i++) lineBase[i] = -1;
    filling    = 0;
    beats      = 0;
    fillBase   = 0;
    expValid   = 0;
    expInstr   = 0;
    expAddr    = 0;
    expReq     = 0;
    expMemAddr = 0;
  endfunction

  always @(posedge clockIn or negedge resetIn) begin
    if (!resetIn) begin
      modelReset();
    end else if (!filling) begin
      if (bus.addrValid) begin
        mSet = int'((bus.addrIn / 16) % 16);
        if (lineBase[mSet] == longint'(bus.addrIn & ~32'hF)) begin
          expValid = 1;
          expInstr = lineWords[mSet][(bus.addrIn / 4) % 4];
          expAddr  = bus.addrIn;
        end else begin
          expValid   = 0;
          filling    = 1;
          beats      = 0;
          fillBase   = bus.addrIn & ~32'hF;
          expReq     = 1;
          expMemAddr = fillBase;
        end
      end else begin
        expValid = 0;
      end
    end else begin
      expValid = 0;
      if (bus.memDataValid) begin
        fillWords[beats] = bus.memData;
        beats++;
        if (beats == 4) begin
          mSet = int'((fillBase / 16) % 16);
          lineBase[mSet] = longint'(fillBase);
          for (int w = 0; w < 4; w++) lineWords[mSet][w] = fillWords[w];
          filling = 0;
          expReq  = 0;
        end
      end
    end
  end

  always @(negedge clockIn) begin
    if (checking && resetIn === 1'b1) begin
      chk("cyc_instrOutValid", {31'b0, bus.instrOutValid}, {31'b0, expValid});
      chk("cyc_instrOut", bus.instrOut, expInstr);
      chk("cyc_instrAddrOut", bus.instrAddrOut, expAddr);
      chk("cyc_memRequest", {31'b0, bus.memRequest}, {31'b0, expReq});
      chk("cyc_memAddr", bus.memAddr, expMemAddr);
    end
  end

  task automatic cyc(input logic av, input logic [31:0] a, input logic dv, input logic [31:0] d);
    bus.addrValid    = av;
    bus.addrIn       = a;
    bus.memDataValid = dv;
    bus.memData      = d;
    @(posedge clockIn);
    #2;
  endtask

  // Supply the 4 beats of the line holding req, one beat every gap cycles.
  task automatic fill(input logic [31:0] req, input int gap);
    logic [31:0] base;
    base = req & ~32'hF;
    for (int b = 0; b < 4; b++) begin
      for (int g = 1; g < gap; g++) cyc(1'b1, req, 1'b0, 32'h0);
      cyc(1'b1, req, 1'b1, memWord(base + 32'(4 * b)));
      if (b < 3) chk("fill_req_held", {31'b0, bus.memRequest}, 32'h1);
      else       chk("fill_req_drop", {31'b0, bus.memRequest}, 32'h0);
    end
  endtask

  initial begin
    modelReset();
    resetIn          = 1'b0;
    bus.addrValid    = 1'b0;
    bus.addrIn       = 32'h0;
    bus.memDataValid = 1'b0;
    bus.memData      = 32'h0;
    repeat (2) @(posedge clockIn);
    #2;
    chk("rst_instrOutValid", {31'b0, bus.instrOutValid}, 32'h0);
    chk("rst_instrOut", bus.instrOut, 32'h0);
    chk("rst_instrAddrOut", bus.instrAddrOut, 32'h0);
    chk("rst_memRequest", {31'b0, bus.memRequest}, 32'h0);
    chk("rst_memAddr", bus.memAddr, 32'h0);
    resetIn  = 1'b1;
    checking = 1'b1;

    // Cold miss on 0x0.
    cyc(1'b1, 32'h0, 1'b0, 32'h0);
    chk("cold_req", {31'b0, bus.memRequest}, 32'h1);
    chk("cold_memAddr", bus.memAddr, 32'h0);
    cyc(1'b1, 32'h0, 1'b1, 32'h00000013);
    cyc(1'b1, 32'h0, 1'b1, 32'h00100093);
    cyc(1'b1, 32'h0, 1'b1, 32'h00200113);
    chk("cold_req_before_last", {31'b0, bus.memRequest}, 32'h1);
    cyc(1'b1, 32'h0, 1'b1, 32'h00300193);
    chk("cold_req_after_last", {31'b0, bus.memRequest}, 32'h0);
    chk("cold_valid_after_last", {31'b0, bus.instrOutValid}, 32'h0);
    cyc(1'b1, 32'h0, 1'b0, 32'h0);
    chk("cold_valid", {31'b0, bus.instrOutValid}, 32'h1);
    chk("cold_instr", bus.instrOut, 32'h00000013);
    chk("cold_addr", bus.instrAddrOut, 32'h0);
    chk("model_pin_cold", expInstr, 32'h00000013);

    // Sequential hits.
    cyc(1'b1, 32'h4, 1'b0, 32'h0);
    chk("hit4_instr", bus.instrOut, 32'h00100093);
    cyc(1'b1, 32'h8, 1'b0, 32'h0);
    chk("hit8_instr", bus.instrOut, 32'h00200113);
    cyc(1'b1, 32'hC, 1'b0, 32'h0);
    chk("hitC_instr", bus.instrOut, 32'h00300193);
    chk("hitC_addr", bus.instrAddrOut, 32'hC);
    chk("hitC_noreq", {31'b0, bus.memRequest}, 32'h0);

    // Stray beat while idle and hitting.
    cyc(1'b1, 32'h0, 1'b1, 32'hDEADBEEF);
    chk("stray_instr0", bus.instrOut, 32'h00000013);
    cyc(1'b1, 32'h4, 1'b0, 32'h0);
    chk("stray_instr4", bus.instrOut, 32'h00100093);

    // Idle request: valid drops, data holds.
    cyc(1'b0, 32'h0, 1'b0, 32'h0);
    chk("idle_valid", {31'b0, bus.instrOutValid}, 32'h0);
    chk("idle_hold", bus.instrOut, 32'h00100093);

    // Conflict eviction with gapped beats; post-fill lookup uses new address.
    cyc(1'b1, 32'h100, 1'b0, 32'h0);
    chk("evict_req", {31'b0, bus.memRequest}, 32'h1);
    chk("evict_memAddr", bus.memAddr, 32'h100);
    fill(32'h100, 3);
    cyc(1'b1, 32'h108, 1'b0, 32'h0);
    chk("evict_valid", {31'b0, bus.instrOutValid}, 32'h1);
    chk("evict_instr", bus.instrOut, 32'hC0DE0108);
    chk("evict_addr", bus.instrAddrOut, 32'h108);
    cyc(1'b1, 32'h0, 1'b0, 32'h0);
    chk("remiss_req", {31'b0, bus.memRequest}, 32'h1);
    chk("remiss_memAddr", bus.memAddr, 32'h0);
    fill(32'h0, 1);
    cyc(1'b1, 32'h8, 1'b0, 32'h0);
    chk("remiss_instr", bus.instrOut, 32'h00200113);

    // Reset in the middle of a fill for 0x40.
    cyc(1'b1, 32'h40, 1'b0, 32'h0);
    chk("mid_req", {31'b0, bus.memRequest}, 32'h1);
    cyc(1'b1, 32'h40, 1'b1, memWord(32'h40));
    cyc(1'b1, 32'h40, 1'b1, memWord(32'h44));
    #1;
    resetIn = 1'b0;
    #1;
    chk("midrst_req", {31'b0, bus.memRequest}, 32'h0);
    chk("midrst_memAddr", bus.memAddr, 32'h0);
    chk("midrst_valid", {31'b0, bus.instrOutValid}, 32'h0);
    @(posedge clockIn);
    #2;
    resetIn = 1'b1;
    cyc(1'b1, 32'h40, 1'b0, 32'h0);
    chk("refill_req", {31'b0, bus.memRequest}, 32'h1);
    chk("refill_memAddr", bus.memAddr, 32'h40);
    fill(32'h40, 1);
    cyc(1'b1, 32'h44, 1'b0, 32'h0);
    chk("refill_instr", bus.instrOut, 32'hC0DE0044);
    cyc(1'b1, 32'h0, 1'b0, 32'h0);
    chk("post_reset_miss0", {31'b0, bus.memRequest}, 32'h1);

    checking = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
